// File: rtl/fp_pkg.sv
// Shared floating-point min/max definitions: controller FSM states and
// IEEE-754 single-precision special-value encodings.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } fp_state_t;

  localparam logic [31:0] FP_NANS  = 32'h7FC0_0000;
  localparam logic [31:0] FP_INFP  = 32'h7F80_0000;
  localparam logic [31:0] FP_INFN  = 32'hFF80_0000;
  localparam logic [31:0] FP_ZEROP = 32'h0000_0000;
  localparam logic [31:0] FP_ZERON = 32'h8000_0000;

endpackage

// File: rtl/fp_minmax_ctrl.sv
// Min/max controller that sequences an external registered comparator (fp_comp).
// Accepts an operand pair, strobes the comparator, samples its response after
// RESP_LAT wait cycles (or flags a timeout) and holds the selected result until
// the consumer takes it.
// Optional feature macro: FP_MINMAX_STICKY_EN adds a sticky invalid/error flag.
module fp_minmax_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned W        = 32,
  parameter int unsigned RESP_LAT = 2,
  parameter int unsigned TIMEOUT  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_op,
  output logic [W-1:0] cmp_in1,
  output logic [W-1:0] cmp_in2,
  output logic         cmp_act,
  input  logic         cmp_eq,
  input  logic         cmp_great,
  input  logic         cmp_less,
  input  logic         cmp_done,
  input  logic         cmp_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
`ifdef FP_MINMAX_STICKY_EN
  input  logic         sticky_clr,
  output logic         sticky_inv,
`endif
  output logic         out_eq,
  output logic         out_inv,
  output logic         out_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  fp_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           op_q, op_d;
  logic [W-1:0]   a_d, b_d, data_d;
  logic           act_d, ready_d, valid_d, eq_d, inv_d, err_d;
  logic           any_flag;

  assign any_flag = cmp_eq | cmp_great | cmp_less;

  // Next state and next value of every registered output.
  // The last sampling opportunity is counter == TIMEOUT-1, so a timeout result
  // becomes visible exactly TIMEOUT cycles after the ISSUE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = cmp_in1;
    b_d     = cmp_in2;
    act_d   = 1'b0;
    valid_d = out_valid;
    data_d  = out_data;
    eq_d    = out_eq;
    inv_d   = out_inv;
    err_d   = out_err;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = ISSUE;
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          act_d   = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CW'(1);
      end
      WAIT: begin
        if ((cnt_q >= CW'(RESP_LAT)) && cmp_done) begin
          state_d = OUT;
          cnt_d   = '0;
          valid_d = 1'b1;
          eq_d    = cmp_eq;
          err_d   = 1'b0;
          if (cmp_inv || !any_flag) begin
            data_d = W'(FP_NANS);
            inv_d  = 1'b1;
          end else begin
            inv_d = 1'b0;
            if (op_q) data_d = (cmp_great || cmp_eq) ? cmp_in1 : cmp_in2;
            else      data_d = (cmp_less  || cmp_eq) ? cmp_in1 : cmp_in2;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = OUT;
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = W'(FP_NANS);
          eq_d    = 1'b0;
          inv_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State, counter, captured operands and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      cmp_in1   <= '0;
      cmp_in2   <= '0;
      cmp_act   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eq    <= 1'b0;
      out_inv   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      cmp_in1   <= a_d;
      cmp_in2   <= b_d;
      cmp_act   <= act_d;
      in_ready  <= ready_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_eq    <= eq_d;
      out_inv   <= inv_d;
      out_err   <= err_d;
    end
  end

`ifdef FP_MINMAX_STICKY_EN
  // Sticky flag for consumed invalid/timeout results; clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_inv <= 1'b0;
    end else if (sticky_clr) begin
      sticky_inv <= 1'b0;
    end else if (out_valid && out_ready && (out_inv || out_err)) begin
      sticky_inv <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/fp_minmax_ctrl.md
FP_MINMAX_CTRL -- requirements
Module: fp_minmax_ctrl

Interface
REQ-001 SHALL have parameter W, default 32: operand width in bits.
REQ-002 SHALL have parameter RESP_LAT, default 2: cycles after issue before the comparator response is sampled.
REQ-003 SHALL have parameter TIMEOUT, default 8: maximum wait cycles after issue before error; TIMEOUT > RESP_LAT.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: operand pair offered.
REQ-007 SHALL have port in_ready, output, 1: block accepts an operand pair.
REQ-008 SHALL have ports in_a and in_b, input, W: operands in IEEE-754 single-precision format.
REQ-009 SHALL have port in_op, input, 1: 0 = min, 1 = max.
REQ-010 SHALL have ports cmp_in1 and cmp_in2, output, W: operands driven to the comparator.
REQ-011 SHALL have port cmp_act, output, 1: comparator activate strobe.
REQ-012 SHALL have ports cmp_eq, cmp_great, cmp_less, cmp_done and cmp_inv, input, 1 each: registered comparator results.
REQ-013 SHALL have port out_valid, input... correction: out_valid, output, 1: result valid.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-015 SHALL have port out_data, output, W: selected result.
REQ-016 SHALL have ports out_eq, out_inv and out_err, output, 1 each: operands equal, invalid comparison, comparator timeout.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT and OUT.
REQ-018 SHALL assert in_ready only in IDLE; in_valid && in_ready SHALL capture in_a, in_b and in_op and move the FSM to ISSUE.
REQ-019 SHALL, in ISSUE, assert cmp_act for exactly one cycle and then enter WAIT with wait counter = 1.
REQ-020 SHALL hold cmp_in1 = captured a and cmp_in2 = captured b from the ISSUE cycle through the sample cycle.
REQ-021 SHALL, in WAIT, increment the counter each cycle and ignore cmp_* inputs while counter < RESP_LAT.
REQ-022 SHALL, when counter >= RESP_LAT and cmp_done = 1, load the result and enter OUT.
REQ-023 SHALL, when counter reaches TIMEOUT without a sampled cmp_done, load out_data = FP_NANS and out_err = 1, then enter OUT.
REQ-024 SHALL, for max, select out_data = a if cmp_great or cmp_eq is set, otherwise b.
REQ-025 SHALL, for min, select out_data = a if cmp_less or cmp_eq is set, otherwise b.
REQ-026 SHALL, if cmp_inv = 1 or no flag among eq/great/less is set, output out_data = FP_NANS (32'h7FC00000) and out_inv = 1.
REQ-027 SHALL set out_eq = cmp_eq when sampled.
REQ-028 SHALL, in OUT, hold out_valid = 1 and all out_* stable until out_ready = 1, then return to IDLE.
REQ-029 SHALL allow no back-to-back acceptance: in_ready is low in the cycle the result is consumed.
REQ-030 SHALL not assert out_inv and out_err together.

Reset
REQ-031 SHALL, on rst low, immediately force the FSM to IDLE, the counter to 0, and cmp_act, cmp_in1, cmp_in2, out_valid, out_data, out_eq, out_inv and out_err to 0.
REQ-032 SHALL, on reset mid-operation, discard the pending operation with no output produced.
REQ-033 SHALL set in_ready = 1 in the first cycle after reset release.

Configuration
REQ-034 SHALL, with FP_MINMAX_STICKY_EN defined, add output sticky_inv and input sticky_clr; sticky_inv is set when a result with out_inv or out_err is consumed, and cleared by sticky_clr (clear wins on simultaneous events); both reset to 0.
REQ-035 SHALL, without FP_MINMAX_STICKY_EN, omit those ports and their logic entirely.

Structure
REQ-036 SHALL place the FSM state enum and the FP_NANS, FP_INFP, FP_INFN, FP_ZEROP and FP_ZERON constants in the shared package fp_pkg.
REQ-037 SHALL instantiate no sub-modules; fp_comp SHALL be connected externally at the top level.

Verification
REQ-038 SHALL cover max(1.0, 2.0): a = 0x3F800000, b = 0x40000000, with fp_comp attached -> out_data = 0x40000000, out_eq = 0, out_inv = 0.
REQ-039 SHALL cover min(-1.0, 1.0): 0xBF800000, 0x3F800000 -> out_data = 0xBF800000.
REQ-040 SHALL cover min(+0, -0): 0x00000000, 0x80000000 -> out_eq = 1, out_data = 0x00000000.
REQ-041 SHALL cover an operand of FP_NANS -> out_data = 0x7FC00000, out_inv = 1, response sampled at counter = RESP_LAT.
REQ-042 SHALL cover cmp_done tied to 0 -> out_err = 1 exactly TIMEOUT cycles after ISSUE; with out_ready low for 5 cycles, the output stays stable throughout.
REQ-043 SHALL cover rst pulsed low during WAIT -> out_valid never asserts, in_ready = 1 after release; with FP_MINMAX_STICKY_EN, sticky_inv is set after the REQ-041 case and cleared by sticky_clr.
